register_file: RTL and testbench
================================

Name: register_file

Overview:
- General-purpose integer register file for the single-cycle RISC-V datapath.
- Two combinational read ports (rs1/rs2 operands) and one synchronous write port (rd writeback).
- 64 entries of 64 bits; entry 0 hardwired to zero per RISC-V convention.

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 6, width of each address port.
- NUM_REGS, 64, number of entries (2**ADDR_WIDTH).

Ports:
- clk  input  1  clock; all writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- address1  input  ADDR_WIDTH  read port 1 address (index 0 of vector is MSB).
- address2  input  ADDR_WIDTH  read port 2 address (index 0 is MSB).
- addressw  input  ADDR_WIDTH  write address (index 0 is MSB).
- writeData  input  DATA_WIDTH  write data (index 0 is MSB).
- writeEn  input  1  write enable, active high.
- read1  output  DATA_WIDTH  contents of register[address1].
- read2  output  DATA_WIDTH  contents of register[address2].

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: rst_n low immediately clears all 64 registers to 0, without waiting for a clock edge. read1/read2 therefore read 0 while reset is held. Writes are ignored while rst_n is low. Registers hold 0 until the first write after rst_n deasserts.
- Write: on posedge clk with rst_n high and writeEn=1, register[addressw] <= writeData.
  - writeEn=0: no register changes.
  - addressw=0: write discarded; register 0 stays 0.
- Read: purely combinational, zero latency. read1 = register[address1], read2 = register[address2].
  - Address 0 always reads 0.
  - Both ports may address the same register simultaneously; both return the same value.
- Read-during-write (same address, same cycle), without the optional feature: read returns the OLD value until the clock edge, then the new value.
- No X propagation: every address value 0..63 is valid; no out-of-range case exists.
- Reset asserted mid-cycle during a pending write: reset wins; the register stays 0.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a combinational bypass on each read port. If writeEn=1, rst_n=1, addressw!=0 and addressw equals that port's address, the port outputs writeData in the same cycle, before the edge. The bypass never applies to address 0.
- Undefined: no bypass; reads return stored contents only, as in Behaviour.

Test Plan:
- Reset: drive rst_n=0 asynchronously after writing 0xDEADBEEF_00000001 to reg 5 -> read of reg 5 returns 0 immediately, before any clk edge; all regs read 0.
- Basic write/read: write 0x0123456789ABCDEF to reg 10 with writeEn=1, next cycle address1=10, address2=10 -> read1=read2=0x0123456789ABCDEF.
- Write enable gating: writeEn=0, addressw=7, writeData=0xFFFF_FFFF_FFFF_FFFF -> reg 7 remains 0 after edge.
- Zero register: writeEn=1, addressw=0, writeData=0xAAAA_AAAA_AAAA_AAAA -> read1 at address 0 returns 0 before and after the edge.
- Full sweep: write value i*0x0101010101010101 to regs 1..63, then read pairs (i, 64-i) -> each read port returns its index-derived value.
- Read-during-write: reg 3 holds 0x11; write 0x22 to reg 3 with address1=3 -> read1=0x11 before the edge and 0x22 after. With REGFILE_WRITE_BYPASS_EN defined -> read1=0x22 before the edge.

Source files
------------

// File: rtl/register_file.sv
// register_file: 64x64 integer register file, 2 async read ports, 1 sync write port.
// Ports: clk, rst_n (async low), address1/address2/addressw, writeData, writeEn, read1, read2.
// Optional REGFILE_WRITE_BYPASS_EN forwards writeData to a read port hitting addressw.
// Vectors are numbered with index 0 as MSB; entry 0 always reads zero.
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:ADDR_WIDTH-1] address1,
    input  logic [0:ADDR_WIDTH-1] address2,
    input  logic [0:ADDR_WIDTH-1] addressw,
    input  logic [0:DATA_WIDTH-1] writeData,
    input  logic                  writeEn,
    output logic [0:DATA_WIDTH-1] read1,
    output logic [0:DATA_WIDTH-1] read2
);

    logic [0:DATA_WIDTH-1] regs [NUM_REGS];

    logic wr_ok;
    logic [0:DATA_WIDTH-1] stored1;
    logic [0:DATA_WIDTH-1] stored2;

    // Writes to entry 0 are dropped so it stays zero.
    assign wr_ok = writeEn && (addressw != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[addressw] <= writeData;
        end
    end

    assign stored1 = (address1 == '0) ? '0 : regs[address1];
    assign stored2 = (address2 == '0) ? '0 : regs[address2];

`ifdef REGFILE_WRITE_BYPASS_EN
    logic hit1;
    logic hit2;

    // wr_ok already excludes address 0, so the bypass never fires there.
    assign hit1 = wr_ok && rst_n && (addressw == address1);
    assign hit2 = wr_ok && rst_n && (addressw == address2);

    assign read1 = hit1 ? writeData : stored1;
    assign read2 = hit2 ? writeData : stored2;
`else
    assign read1 = stored1;
    assign read2 = stored2;
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
// Covers reset, write gating, zero register, full sweep and read-during-write.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [0:5]  address1;
    logic [0:5]  address2;
    logic [0:5]  addressw;
    logic [0:63] writeData;
    logic        writeEn;
    logic [0:63] read1;
    logic [0:63] read2;

    int n_cmp;
    int n_err;

    register_file dut (
        .clk(clk),
        .rst_n(rst_n),
        .address1(address1),
        .address2(address2),
        .addressw(addressw),
        .writeData(writeData),
        .writeEn(writeEn),
        .read1(read1),
        .read2(read2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d);
        addressw  = a;
        writeData = d;
        writeEn   = 1'b1;
        tick();
        writeEn   = 1'b0;
    endtask

    localparam logic [63:0] STEP = 64'h0101010101010101;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        address1  = '0;
        address2  = '0;
        addressw  = '0;
        writeData = '0;
        writeEn   = 1'b0;

        #2;
        address1 = 6'd5;
        #1;
        check("rst_init_r5", read1, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Async reset after a write: clears without a clock edge.
        wr(6'd5, 64'hDEADBEEF_00000001);
        address1 = 6'd5;
        #1;
        check("pre_rst_r5", read1, 64'hDEADBEEF_00000001);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_r5", read1, 64'h0);
        for (int i = 0; i < 64; i++) begin
            address1 = 6'(i);
            address2 = 6'(63 - i);
            #0.1;
            check("rst_sweep1", read1, 64'h0);
            check("rst_sweep2", read2, 64'h0);
        end

        // Writes are ignored while reset is held.
        addressw  = 6'd6;
        writeData = 64'h5555;
        writeEn   = 1'b1;
        tick();
        writeEn   = 1'b0;
        address1  = 6'd6;
        #1;
        check("wr_in_rst", read1, 64'h0);
        rst_n = 1'b1;
        tick();

        // Basic write/read, both ports same register.
        wr(6'd10, 64'h0123456789ABCDEF);
        address1 = 6'd10;
        address2 = 6'd10;
        #1;
        check("basic_r1", read1, 64'h0123456789ABCDEF);
        check("basic_r2", read2, 64'h0123456789ABCDEF);

        // Write enable low: no change.
        addressw  = 6'd7;
        writeData = 64'hFFFF_FFFF_FFFF_FFFF;
        writeEn   = 1'b0;
        tick();
        address1 = 6'd7;
        #1;
        check("wen_gate", read1, 64'h0);

        // Zero register ignores writes.
        address1  = 6'd0;
        addressw  = 6'd0;
        writeData = 64'hAAAA_AAAA_AAAA_AAAA;
        writeEn   = 1'b1;
        #1;
        check("zero_pre", read1, 64'h0);
        tick();
        writeEn = 1'b0;
        check("zero_post", read1, 64'h0);

        // Full sweep.
        for (int i = 1; i < 64; i++) begin
            wr(6'(i), STEP * 64'(i));
        end
        for (int i = 1; i < 64; i++) begin
            address1 = 6'(i);
            address2 = 6'(64 - i);
            #1;
            check("sweep_r1", read1, STEP * 64'(i));
            check("sweep_r2", read2, STEP * 64'(64 - i));
        end

        // Read-during-write on reg 3.
        wr(6'd3, 64'h11);
        address1  = 6'd3;
        address2  = 6'd3;
        addressw  = 6'd3;
        writeData = 64'h22;
        writeEn   = 1'b1;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("rdw_pre", read1, 64'h22);
`else
        check("rdw_pre", read1, 64'h11);
`endif
        tick();
        writeEn = 1'b0;
        check("rdw_post1", read1, 64'h22);
        check("rdw_post2", read2, 64'h22);

        // Reset mid-cycle with a pending write: reset wins.
        addressw  = 6'd4;
        writeData = 64'h1234;
        writeEn   = 1'b1;
        #2;
        rst_n = 1'b0;
        tick();
        writeEn  = 1'b0;
        rst_n    = 1'b1;
        address1 = 6'd4;
        address2 = 6'd3;
        #1;
        check("rst_win_r4", read1, 64'h0);
        check("rst_win_r3", read2, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
